// File: rtl/mpm_port_ctrl_if.sv
// Request/response and memory-side bundle for the multi-port memory controller.
// master = requester plus memory model, slave = mpm_port_ctrl.
interface mpm_port_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned PORTS = 2
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [PORTS-1:0]            req_valid;
  logic [PORTS-1:0]            req_ready;
  logic [PORTS-1:0]            req_we;
  logic [PORTS-1:0][AW-1:0]    req_addr;
  logic [PORTS-1:0][WIDTH-1:0] req_wdata;
  logic [PORTS-1:0]            rsp_valid;
  logic [PORTS-1:0][WIDTH-1:0] rsp_data;
  logic [PORTS-1:0][AW-1:0]    mem_addr;
  logic [PORTS-1:0][WIDTH-1:0] mem_d;
  logic [PORTS-1:0]            mem_en;
  logic [PORTS-1:0][WIDTH-1:0] mem_q;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_q,
    input  req_ready, rsp_valid, rsp_data, mem_addr, mem_d, mem_en
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_q,
    output req_ready, rsp_valid, rsp_data, mem_addr, mem_d, mem_en
  );
endinterface

// File: rtl/mpm_port_ctrl.sv
// Port controller for a multi-port memory: clears the array after reset, then
// forwards requests with lowest-index-wins arbitration on same-address writes.
module mpm_port_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 256,
  parameter int unsigned PORTS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mpm_port_ctrl_if.slave      bus,
  output logic                init_done,
  output logic [15:0]         conflict_cnt
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned SEG = DEPTH / PORTS;
  localparam int unsigned CW  = (SEG > 1) ? $clog2(SEG) : 1;
  localparam int unsigned NW  = $clog2(PORTS + 1);

  typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   init_cnt;
  logic            init_last;
  logic [PORTS-1:0] blocked;
  logic [PORTS-1:0] rd_acc;
  logic [PORTS-1:0] rsp_pend;
  logic [NW-1:0]   n_blocked;
  logic [16:0]     cnt_sum;
  logic [15:0]     conflict_next;

  assign init_last = (init_cnt == CW'(SEG - 1));

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= INIT;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    if (state == INIT && init_last) state_next = RUN;
  end

  // Same-address write detection; a lower-index writer always wins
  always_comb begin
    blocked = '0;
    for (int p = 0; p < PORTS; p++) begin
      for (int q = 0; q < PORTS; q++) begin
        if (q < p && state == RUN &&
            bus.req_valid[p] && bus.req_we[p] &&
            bus.req_valid[q] && bus.req_we[q] &&
            bus.req_addr[q] == bus.req_addr[p]) begin
          blocked[p] = 1'b1;
        end
      end
    end
  end

  // Output logic: clear sweep in INIT, request pass-through in RUN
  always_comb begin
    bus.req_ready = '0;
    bus.mem_en    = '0;
    bus.mem_addr  = '0;
    bus.mem_d     = '0;
    rd_acc        = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (state == INIT) begin
        bus.mem_en[p]   = 1'b1;
        bus.mem_addr[p] = AW'(p * SEG) + AW'(init_cnt);
      end else begin
        bus.req_ready[p] = ~blocked[p];
        bus.mem_addr[p]  = bus.req_addr[p];
        bus.mem_d[p]     = bus.req_wdata[p];
        bus.mem_en[p]    = bus.req_valid[p] & ~blocked[p] & bus.req_we[p];
        rd_acc[p]        = bus.req_valid[p] & ~blocked[p] & ~bus.req_we[p];
      end
    end
  end

  // Memory read data is registered in the array, so it lines up with rsp_pend
  always_comb begin
    bus.rsp_valid = rsp_pend;
    bus.rsp_data  = '0;
    for (int p = 0; p < PORTS; p++) begin
      if (rsp_pend[p]) bus.rsp_data[p] = bus.mem_q[p];
    end
  end

  always_comb begin
    n_blocked = '0;
    for (int p = 0; p < PORTS; p++) n_blocked = n_blocked + NW'(blocked[p]);
  end

  assign cnt_sum       = {1'b0, conflict_cnt} + 17'(n_blocked);
  assign conflict_next = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      init_cnt     <= '0;
      init_done    <= 1'b0;
      rsp_pend     <= '0;
      conflict_cnt <= '0;
    end else begin
      init_cnt     <= (state == INIT && !init_last) ? init_cnt + CW'(1) : '0;
      init_done    <= (state_next == RUN);
      rsp_pend     <= rd_acc;
      conflict_cnt <= conflict_next;
    end
  end
endmodule

// File: tb/tb_mpm_port_ctrl.sv
// Directed bench for mpm_port_ctrl with a read-first multi-port memory model.
module tb_mpm_port_ctrl;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned PORTS = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        preload = 1'b1;
  logic        init_done;
  logic [15:0] conflict_cnt;
  int          ntests = 0;
  int          nfail = 0;
  logic [7:0]  mem [DEPTH];

  always #5 clk = ~clk;

  mpm_port_ctrl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS)) bus ();

  mpm_port_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PORTS(PORTS)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .init_done    (init_done),
    .conflict_cnt (conflict_cnt)
  );

  // Memory model: registered read returning pre-write contents
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'hC3;
    end else begin
      for (int p = 0; p < PORTS; p++)
        if (bus.mem_en[p]) mem[bus.mem_addr[p]] <= bus.mem_d[p];
    end
    for (int p = 0; p < PORTS; p++) bus.mem_q[p] <= mem[bus.mem_addr[p]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.req_valid = '0;
    bus.req_we    = '0;
  endtask

  task automatic drive(input int p, input logic we, input logic [7:0] addr, input logic [7:0] data);
    bus.req_valid[p] = 1'b1;
    bus.req_we[p]    = we;
    bus.req_addr[p]  = addr;
    bus.req_wdata[p] = data;
  endtask

  // Called at a negedge right after reset release; leaves the bench in RUN
  task automatic init_phase();
    for (int i = 0; i < 128; i++) begin
      check("init_addr0", 32'(bus.mem_addr[0]), 32'(i));
      check("init_addr1", 32'(bus.mem_addr[1]), 32'(128 + i));
      check("init_en", 32'(bus.mem_en), 32'h3);
      check("init_d", 32'(bus.mem_d), 32'h0);
      check("init_ready", 32'(bus.req_ready), 32'h0);
      check("init_done_low", 32'(init_done), 32'h0);
      step();
    end
    check("init_done_high", 32'(init_done), 32'h1);
    check("run_ready_idle", 32'(bus.req_ready), 32'h3);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    repeat (3) @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    check("rst_init_done", 32'(init_done), 32'h0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("rst_conflict", 32'(conflict_cnt), 32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    rst_n = 1'b1;
    init_phase();

    // Write then read through the other port
    drive(0, 1'b1, 8'h10, 8'hA5);
    #1;
    check("wr_ready", 32'(bus.req_ready), 32'h3);
    check("wr_en", 32'(bus.mem_en), 32'h1);
    check("wr_addr", 32'(bus.mem_addr[0]), 32'h10);
    check("wr_d", 32'(bus.mem_d[0]), 32'hA5);
    step();
    idle();
    drive(1, 1'b0, 8'h10, 8'h00);
    #1;
    check("rd_ready", 32'(bus.req_ready), 32'h3);
    check("rd_en", 32'(bus.mem_en), 32'h0);
    step();
    idle();
    check("rd_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    check("rd_rsp_data1", 32'(bus.rsp_data[1]), 32'hA5);
    check("rd_rsp_data0", 32'(bus.rsp_data[0]), 32'h0);
    step();
    check("rd_rsp_once", 32'(bus.rsp_valid), 32'h0);
    check("rd_rsp_zero", 32'(bus.rsp_data[1]), 32'h0);

    // Same-address write conflict
    drive(0, 1'b1, 8'h20, 8'h11);
    drive(1, 1'b1, 8'h20, 8'h22);
    #1;
    check("cf_ready", 32'(bus.req_ready), 32'h1);
    check("cf_en", 32'(bus.mem_en), 32'h1);
    step();
    check("cf_cnt1", 32'(conflict_cnt), 32'h1);
    idle();
    drive(1, 1'b1, 8'h20, 8'h22);
    #1;
    check("cf_retry_ready", 32'(bus.req_ready), 32'h3);
    check("cf_retry_en", 32'(bus.mem_en), 32'h2);
    step();
    idle();
    drive(0, 1'b0, 8'h20, 8'h00);
    step();
    idle();
    check("cf_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    check("cf_rsp_data", 32'(bus.rsp_data[0]), 32'h22);
    check("cf_cnt_hold", 32'(conflict_cnt), 32'h1);

    // Same-cycle read and write to one address returns old data
    drive(0, 1'b1, 8'h30, 8'h77);
    drive(1, 1'b0, 8'h30, 8'h00);
    #1;
    check("rw_ready", 32'(bus.req_ready), 32'h3);
    check("rw_en", 32'(bus.mem_en), 32'h1);
    step();
    idle();
    check("rw_rsp_valid", 32'(bus.rsp_valid), 32'h2);
    check("rw_rsp_old", 32'(bus.rsp_data[1]), 32'h0);
    drive(1, 1'b0, 8'h30, 8'h00);
    step();
    idle();
    check("rw_rsp_new", 32'(bus.rsp_data[1]), 32'h77);

    // Back-to-back reads on port 0
    drive(0, 1'b0, 8'h10, 8'h00);
    step();
    drive(0, 1'b0, 8'h30, 8'h00);
    check("b2b_valid1", 32'(bus.rsp_valid), 32'h1);
    check("b2b_data1", 32'(bus.rsp_data[0]), 32'hA5);
    step();
    idle();
    check("b2b_valid2", 32'(bus.rsp_valid), 32'h1);
    check("b2b_data2", 32'(bus.rsp_data[0]), 32'h77);

    // Sustained conflict saturates the counter
    drive(0, 1'b1, 8'h20, 8'h11);
    drive(1, 1'b1, 8'h20, 8'h22);
    repeat (100) step();
    check("sat_mid", 32'(conflict_cnt), 32'd101);
    repeat (69900) step();
    check("sat_full", 32'(conflict_cnt), 32'hFFFF);
    check("sat_ready", 32'(bus.req_ready), 32'h1);
    step();
    check("sat_hold", 32'(conflict_cnt), 32'hFFFF);
    idle();

    // Reset mid-RUN with a read being accepted
    drive(1, 1'b0, 8'h10, 8'h00);
    rst_n = 1'b0;
    #1;
    check("mr_ready", 32'(bus.req_ready), 32'h3);
    step();
    idle();
    check("mr_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    check("mr_rsp_data", 32'(bus.rsp_data), 32'h0);
    check("mr_init_done", 32'(init_done), 32'h0);
    check("mr_conflict", 32'(conflict_cnt), 32'h0);
    rst_n = 1'b1;
    init_phase();

    // Every location reads back as zero
    for (int k = 0; k <= 128; k++) begin
      if (k > 0) begin
        check("rb_valid", 32'(bus.rsp_valid), 32'h3);
        check("rb_data0", 32'(bus.rsp_data[0]), 32'h0);
        check("rb_data1", 32'(bus.rsp_data[1]), 32'h0);
      end
      if (k < 128) begin
        drive(0, 1'b0, 8'(k), 8'h00);
        drive(1, 1'b0, 8'(128 + k), 8'h00);
      end else begin
        idle();
      end
      step();
    end
    check("rb_end_valid", 32'(bus.rsp_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule

// File: doc/mpm_port_ctrl.md
MPM_PORT_CTRL -- requirements
Module: mpm_port_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width per port.
REQ-002 The block SHALL have parameter DEPTH, default 256, meaning memory entries; DEPTH SHALL be a multiple of PORTS.
REQ-003 The block SHALL have parameter PORTS, default 2, meaning number of independent request ports.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port req_valid[PORTS-1:0], input, 1 bit each: request present.
REQ-007 The block SHALL have port req_ready[PORTS-1:0], output, 1 bit each: request accepted this cycle when high with req_valid.
REQ-008 The block SHALL have port req_we[PORTS-1:0], input, 1 bit each: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr[PORTS-1:0], input, $clog2(DEPTH) bits each: request address.
REQ-010 The block SHALL have port req_wdata[PORTS-1:0], input, WIDTH bits each: write data.
REQ-011 The block SHALL have port rsp_valid[PORTS-1:0], output, 1 bit each: read data valid.
REQ-012 The block SHALL have port rsp_data[PORTS-1:0], output, WIDTH bits each: read data.
REQ-013 The block SHALL have port mem_addr[PORTS-1:0], output, $clog2(DEPTH) bits each: address to the multi-port memory.
REQ-014 The block SHALL have port mem_d[PORTS-1:0], output, WIDTH bits each: write data to memory.
REQ-015 The block SHALL have port mem_en[PORTS-1:0], output, 1 bit each: write enable to memory.
REQ-016 The block SHALL have port mem_q[PORTS-1:0], input, WIDTH bits each: registered read data from memory, valid 1 cycle after address.
REQ-017 The block SHALL have port init_done, output, 1 bit: memory clear complete, requests enabled.
REQ-018 The block SHALL have port conflict_cnt, output, 16 bits: saturating count of stalled write-conflict cycles.

Function
REQ-019 FSM SHALL have two states, INIT and RUN; reset enters INIT with init counter = 0.
REQ-020 In INIT, each port p SHALL drive mem_en=1, mem_d=0, mem_addr = p*(DEPTH/PORTS) + init counter; req_ready SHALL be 0 on all ports.
REQ-021 Init counter SHALL increment each INIT cycle; in the cycle it equals DEPTH/PORTS-1, the FSM SHALL move to RUN at the next edge; INIT lasts exactly DEPTH/PORTS cycles.
REQ-022 init_done SHALL be a register equal to 1 exactly when the FSM is in RUN.
REQ-023 In RUN, mem_addr[p] SHALL equal req_addr[p] and mem_d[p] SHALL equal req_wdata[p] combinationally.
REQ-024 In RUN, port p SHALL be blocked when req_valid[p]&req_we[p] and some lower-index q has req_valid[q]&req_we[q]&(req_addr[q]==req_addr[p]); the lowest index always wins.
REQ-025 req_ready[p] SHALL be 1 in RUN unless port p is blocked; ready is combinational from valid/we/addr.
REQ-026 mem_en[p] SHALL equal req_valid[p]&req_ready[p]&req_we[p] in RUN.
REQ-027 An accepted read on port p in cycle t SHALL produce rsp_valid[p]=1 and rsp_data[p]=mem_q[p] in cycle t+1 only; back-to-back reads SHALL give back-to-back responses.
REQ-028 A read and a write to the same address in the same cycle SHALL both be accepted; the read SHALL return the old data.
REQ-029 rsp_data[p] SHALL be 0 whenever rsp_valid[p] is 0.
REQ-030 conflict_cnt SHALL increment by the number of blocked ports each cycle and saturate at 16'hFFFF with no wrap.

Reset
REQ-031 rst_n=0 sampled at a rising edge SHALL force INIT, init counter 0, init_done 0, rsp_valid 0, conflict_cnt 0, at any time, including mid-INIT or mid-RUN.
REQ-032 A read accepted in the cycle before reset SHALL NOT produce rsp_valid after reset.

Verification
REQ-033 Reset release with defaults -> INIT 128 cycles, port0 clears 0..127, port1 clears 128..255; init_done rises on cycle 128.
REQ-034 Port0 write addr 0x10 data 0xA5, then port1 read 0x10 -> rsp_valid[1] one cycle after accept, rsp_data[1]=0xA5.
REQ-035 Both ports write addr 0x20 (0x11 on p0, 0x22 on p1) in one cycle -> req_ready[0]=1, req_ready[1]=0, conflict_cnt=1; next cycle p1 accepted; the final read returns 0x22.
REQ-036 Same cycle: p0 writes 0x30=0x77 and p1 reads 0x30 (old value 0x00) -> both accepted; p1 response = 0x00.
REQ-037 Force a conflict on every cycle for 70000 cycles -> conflict_cnt holds 16'hFFFF.
REQ-038 Assert rst_n=0 for one cycle mid-RUN with a read outstanding -> no rsp_valid, init_done=0, full INIT repeats, and all addresses read back as 0.
